// File: rtl/comparador_serial.sv
// Bit-serial magnitude comparator: captures two WIDTH-bit operands on a start
// request and scans them MSB-first, one bit per clock, unsigned or signed.
module comparador_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iniciar,
    input  logic             sinal,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             ocupado,
    output logic             pronto,
    output logic             Amaior,
    output logic             igual,
    output logic             Amenor
);

    localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] IDX_MSB = IW'(WIDTH - 1);

    typedef enum logic {
        OCIOSO  = 1'b0,
        COMPARA = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] regA_q, regA_d;
    logic [WIDTH-1:0] regB_q, regB_d;
    logic             modo_q, modo_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             pronto_q, pronto_d;
    logic             amaior_q, amaior_d;
    logic             igual_q, igual_d;
    logic             amenor_q, amenor_d;

    logic             bitA;
    logic             bitB;
    logic             aWins;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= OCIOSO;
            regA_q   <= '0;
            regB_q   <= '0;
            modo_q   <= 1'b0;
            idx_q    <= '0;
            pronto_q <= 1'b0;
            amaior_q <= 1'b0;
            igual_q  <= 1'b0;
            amenor_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            regA_q   <= regA_d;
            regB_q   <= regB_d;
            modo_q   <= modo_d;
            idx_q    <= idx_d;
            pronto_q <= pronto_d;
            amaior_q <= amaior_d;
            igual_q  <= igual_d;
            amenor_q <= amenor_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        regA_d   = regA_q;
        regB_d   = regB_q;
        modo_d   = modo_q;
        idx_d    = idx_q;
        pronto_d = 1'b0;
        amaior_d = amaior_q;
        igual_d  = igual_q;
        amenor_d = amenor_q;
        bitA     = regA_q[idx_q];
        bitB     = regB_q[idx_q];
        // In signed mode the sign bit carries inverted weight.
        aWins    = (modo_q && (idx_q == IDX_MSB)) ? ~bitA : bitA;

        case (state_q)
            OCIOSO: begin
                if (iniciar) begin
                    regA_d   = A;
                    regB_d   = B;
                    modo_d   = sinal;
                    idx_d    = IDX_MSB;
                    amaior_d = 1'b0;
                    igual_d  = 1'b0;
                    amenor_d = 1'b0;
                    state_d  = COMPARA;
                end
            end
            COMPARA: begin
                if (bitA != bitB) begin
                    amaior_d = aWins;
                    amenor_d = ~aWins;
                    pronto_d = 1'b1;
                    state_d  = OCIOSO;
                end else if (idx_q == '0) begin
                    igual_d  = 1'b1;
                    pronto_d = 1'b1;
                    state_d  = OCIOSO;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            default: state_d = OCIOSO;
        endcase
    end

    assign ocupado = (state_q == COMPARA);
    assign pronto  = pronto_q;
    assign Amaior  = amaior_q;
    assign igual   = igual_q;
    assign Amenor  = amenor_q;

endmodule

// File: tb/tb_comparador_serial.sv
// Directed and randomised checks of comparador_serial (WIDTH=8): results,
// latency, busy handling, reset behaviour and back-to-back starts.
module tb_comparador_serial;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             iniciar;
    logic             sinal;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             ocupado;
    logic             pronto;
    logic             Amaior;
    logic             igual;
    logic             Amenor;

    int checks = 0;
    int errors = 0;

    comparador_serial #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .iniciar (iniciar),
        .sinal   (sinal),
        .A       (A),
        .B       (B),
        .ocupado (ocupado),
        .pronto  (pronto),
        .Amaior  (Amaior),
        .igual   (igual),
        .Amenor  (Amenor)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a start request for exactly one edge; leaves us 1 time unit after t0.
    task automatic startOp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
        iniciar = 1'b1;
        A       = a;
        B       = b;
        sinal   = s;
        @(posedge clk);
        #1;
        iniciar = 1'b0;
        A       = WIDTH'($urandom);
        B       = WIDTH'($urandom);
        sinal   = 1'($urandom);
    endtask

    // Waits (bounded) for pronto; lat = edges after t0, -1 on timeout.
    task automatic waitPronto(output int lat, output int busyCycles);
        lat        = -1;
        busyCycles = 0;
        for (int c = 1; c <= WIDTH + 4; c++) begin
            if (ocupado) busyCycles++;
            @(posedge clk);
            #1;
            if (pronto) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst     = 1'b1;
        iniciar = 1'b1;
        sinal   = 1'b0;
        A       = 8'h12;
        B       = 8'h34;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({ocupado, pronto, Amaior, igual, Amenor} !== 5'b00000) begin
                errors++;
                $display("[TB] FAIL reset_hold: got %b expected 00000", {ocupado, pronto, Amaior, igual, Amenor});
            end
        end
        rst     = 1'b0;
        iniciar = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({ocupado, pronto, Amaior, igual, Amenor} !== 5'b00000) begin
                errors++;
                $display("[TB] FAIL reset_idle: got %b expected 00000", {ocupado, pronto, Amaior, igual, Amenor});
            end
        end
    endtask

    task automatic test_equal_lsb;
        int lat;
        int busy;
        startOp(8'h5A, 8'h5A, 1'b0);
        waitPronto(lat, busy);
        checks++;
        if (lat !== 8) begin
            errors++;
            $display("[TB] FAIL equal_latency: got %0d expected 8", lat);
        end
        checks++;
        if (busy !== 8) begin
            errors++;
            $display("[TB] FAIL equal_busy_cycles: got %0d expected 8", busy);
        end
        checks++;
        if ({Amaior, igual, Amenor} !== 3'b010) begin
            errors++;
            $display("[TB] FAIL equal_result: got %b expected 010", {Amaior, igual, Amenor});
        end
        @(posedge clk);
        #1;
        checks++;
        if ({ocupado, pronto, Amaior, igual, Amenor} !== 5'b00010) begin
            errors++;
            $display("[TB] FAIL equal_hold: got %b expected 00010", {ocupado, pronto, Amaior, igual, Amenor});
        end

        startOp(8'h13, 8'h12, 1'b0);
        checks++;
        if ({ocupado, pronto, Amaior, igual, Amenor} !== 5'b10000) begin
            errors++;
            $display("[TB] FAIL start_clears: got %b expected 10000", {ocupado, pronto, Amaior, igual, Amenor});
        end
        waitPronto(lat, busy);
        checks++;
        if (lat !== 8) begin
            errors++;
            $display("[TB] FAIL lsb_latency: got %0d expected 8", lat);
        end
        checks++;
        if ({Amaior, igual, Amenor} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL lsb_result: got %b expected 100", {Amaior, igual, Amenor});
        end
    endtask

    task automatic test_sign;
        int lat;
        int busy;
        startOp(8'h80, 8'h7F, 1'b0);
        waitPronto(lat, busy);
        checks++;
        if (lat !== 1 || {Amaior, igual, Amenor} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL unsigned_msb: got lat=%0d res=%b expected lat=1 res=100", lat, {Amaior, igual, Amenor});
        end
        startOp(8'h80, 8'h7F, 1'b1);
        waitPronto(lat, busy);
        checks++;
        if (lat !== 1 || {Amaior, igual, Amenor} !== 3'b001) begin
            errors++;
            $display("[TB] FAIL signed_msb: got lat=%0d res=%b expected lat=1 res=001", lat, {Amaior, igual, Amenor});
        end
        startOp(8'hFE, 8'hFF, 1'b1);
        waitPronto(lat, busy);
        checks++;
        if (lat !== 8 || {Amaior, igual, Amenor} !== 3'b001) begin
            errors++;
            $display("[TB] FAIL signed_negatives: got lat=%0d res=%b expected lat=8 res=001", lat, {Amaior, igual, Amenor});
        end
    endtask

    task automatic test_busy;
        int pulses;
        int lat;
        pulses = 0;
        lat    = -1;
        startOp(8'h01, 8'h02, 1'b0);
        for (int c = 1; c <= 14; c++) begin
            if (c == 3) begin
                iniciar = 1'b1;
                A       = 8'hFF;
                B       = 8'h00;
            end else begin
                iniciar = 1'b0;
            end
            @(posedge clk);
            #1;
            if (pronto) begin
                pulses++;
                if (lat < 0) lat = c;
            end
        end
        iniciar = 1'b0;
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("[TB] FAIL busy_pulses: got %0d expected 1", pulses);
        end
        checks++;
        if (lat !== 7 || {Amaior, igual, Amenor} !== 3'b001) begin
            errors++;
            $display("[TB] FAIL busy_result: got lat=%0d res=%b expected lat=7 res=001", lat, {Amaior, igual, Amenor});
        end
    endtask

    task automatic test_reset_mid;
        int pulses;
        int lat;
        int busy;
        pulses = 0;
        startOp(8'h00, 8'h00, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({ocupado, pronto, Amaior, igual, Amenor} !== 5'b00000) begin
            errors++;
            $display("[TB] FAIL reset_mid_outputs: got %b expected 00000", {ocupado, pronto, Amaior, igual, Amenor});
        end
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (pronto || ocupado) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("[TB] FAIL reset_mid_quiet: got %0d active cycles expected 0", pulses);
        end
        startOp(8'h00, 8'h00, 1'b0);
        waitPronto(lat, busy);
        checks++;
        if (lat !== 8 || {Amaior, igual, Amenor} !== 3'b010) begin
            errors++;
            $display("[TB] FAIL reset_mid_restart: got lat=%0d res=%b expected lat=8 res=010", lat, {Amaior, igual, Amenor});
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        int busy;
        startOp(8'h5A, 8'h5A, 1'b0);
        waitPronto(lat, busy);
        startOp(8'hC0, 8'h40, 1'b0);
        checks++;
        if ({ocupado, pronto, Amaior, igual, Amenor} !== 5'b10000) begin
            errors++;
            $display("[TB] FAIL b2b_accept: got %b expected 10000", {ocupado, pronto, Amaior, igual, Amenor});
        end
        waitPronto(lat, busy);
        checks++;
        if (lat !== 1 || {ocupado, Amaior, igual, Amenor} !== 4'b0100) begin
            errors++;
            $display("[TB] FAIL b2b_result: got lat=%0d out=%b expected lat=1 out=0100", lat, {ocupado, Amaior, igual, Amenor});
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({ocupado, pronto, Amaior, igual, Amenor} !== 5'b00000) begin
            errors++;
            $display("[TB] FAIL reset_in_pronto: got %b expected 00000", {ocupado, pronto, Amaior, igual, Amenor});
        end
    endtask

    task automatic test_random;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             s;
        logic [2:0]       expRes;
        int               expLat;
        int               lat;
        int               busy;
        for (int n = 0; n < 1000; n++) begin
            a = WIDTH'($urandom);
            b = (n % 10 == 0) ? a : WIDTH'($urandom);
            s = 1'($urandom);
            if (a == b) expRes = 3'b010;
            else if (s ? ($signed(a) > $signed(b)) : (a > b)) expRes = 3'b100;
            else expRes = 3'b001;
            expLat = WIDTH;
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (a[i] != b[i]) begin
                    expLat = WIDTH - i;
                    break;
                end
            end
            startOp(a, b, s);
            waitPronto(lat, busy);
            checks++;
            if (lat !== expLat || {Amaior, igual, Amenor} !== expRes) begin
                errors++;
                $display("[TB] FAIL random a=%h b=%h s=%b: got lat=%0d res=%b expected lat=%0d res=%b",
                         a, b, s, lat, {Amaior, igual, Amenor}, expLat, expRes);
            end
        end
    endtask

    initial begin
        rst     = 1'b1;
        iniciar = 1'b0;
        sinal   = 1'b0;
        A       = '0;
        B       = '0;
        test_reset;
        test_equal_lsb;
        test_sign;
        test_busy;
        test_reset_mid;
        test_back_to_back;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
